// File: rtl/alu_exec_unit.sv
// Two-stage execute ALU (S1 operand capture, S2 result register) with valid/ready on both sides.
// Define ALU_EXEC_FLAGS_EN to add registered carry/overflow/negative outputs aligned with result.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
`ifdef ALU_EXEC_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic             s1_valid;
  logic [2:0]       s1_ctrl;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_ready;
  logic             s2_ready;

  logic [WIDTH-1:0] nxt_result;
  logic             nxt_illegal;

  // Both ready terms are combinational so a full pipe can drain and refill on one edge.
  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  always_comb begin
    nxt_result  = '0;
    nxt_illegal = 1'b0;
    case (s1_ctrl)
      OP_ADD:  nxt_result = s1_a + s1_b;
      OP_SUB:  nxt_result = s1_a - s1_b;
      OP_AND:  nxt_result = s1_a & s1_b;
      OP_OR:   nxt_result = s1_a | s1_b;
      OP_SLT:  nxt_result[0] = $signed(s1_a) < $signed(s1_b);
      default: nxt_illegal = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_FLAGS_EN
  logic nxt_carry;
  logic nxt_overflow;

  // Carry is derived from the wrapped result to avoid a WIDTH+1 adder copy.
  always_comb begin
    nxt_carry    = 1'b0;
    nxt_overflow = 1'b0;
    case (s1_ctrl)
      OP_ADD: begin
        nxt_carry    = nxt_result < s1_a;
        nxt_overflow = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                       (nxt_result[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        nxt_carry    = s1_a >= s1_b;
        nxt_overflow = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                       (nxt_result[WIDTH-1] != s1_a[WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
    end else if (s2_ready && s1_valid) begin
      carry    <= nxt_carry;
      overflow <= nxt_overflow;
      negative <= nxt_result[WIDTH-1];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ctrl <= alu_control;
        s1_a    <= src_a;
        s1_b    <= src_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= nxt_result;
        zero    <= (nxt_result == '0);
        illegal <= nxt_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized traffic against a queue model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
`ifdef ALU_EXEC_FLAGS_EN
  logic        carry;
  logic        overflow;
  logic        negative;
`endif

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
`ifdef ALU_EXEC_FLAGS_EN
    , .carry(carry), .overflow(overflow), .negative(negative)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  always @(posedge clk) edges = edges + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] r;
    logic        z, il, c, v, n;
    int          acc;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    e.r = '0; e.il = 0; e.c = 0; e.v = 0; e.acc = 0;
    case (op)
      3'd0: begin
        e.r = 32'(ua + ub);
        e.c = (ua + ub) > 64'hFFFF_FFFF;
        e.v = (sa + sb) > SMAX || (sa + sb) < SMIN;
      end
      3'd1: begin
        e.r = 32'(ua - ub);
        e.c = ua >= ub;
        e.v = (sa - sb) > SMAX || (sa - sb) < SMIN;
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
      default: e.il = 1;
    endcase
    e.z = (e.r == 0);
    e.n = e.r[31];
    return e;
  endfunction

  exp_t q[$];

  // Per-cycle compare against the model queue; an op becomes visible one edge after capture.
  always @(negedge clk) begin : cmp
    exp_t e;
    logic exp_ov;
    if (!rst) begin
      q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
    end else begin
      exp_ov = (q.size() > 0) && (edges - q[0].acc >= 1);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      if (out_valid && exp_ov) begin
        chk("result", result, q[0].r);
        chk("zero", zero, q[0].z);
        chk("illegal", illegal, q[0].il);
`ifdef ALU_EXEC_FLAGS_EN
        chk("flags", {carry, overflow, negative}, {q[0].c, q[0].v, q[0].n});
`endif
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(alu_control, src_a, src_b);
        e.acc = edges + 1;
        q.push_back(e);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that took the op.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1; alu_control = op; src_a = a; src_b = b;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] r, input logic z,
                            input logic il, input bit chk_fl, input logic [2:0] fl);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_result"}, result, r);
    chk({name, "_zero"}, zero, z);
    chk({name, "_illegal"}, illegal, il);
`ifdef ALU_EXEC_FLAGS_EN
    if (chk_fl) chk({name, "_flags"}, {carry, overflow, negative}, fl);
`else
    if (chk_fl && fl === 3'bzzz) chk({name, "_flags_unused"}, 0, 1);
`endif
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 0; in_valid = 0; out_ready = 1; alu_control = '0; src_a = '0; src_b = '0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_result", result, 0);
    chk("reset_zero", zero, 0);
    chk("reset_illegal", illegal, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;

    // 1: latency of ADD 5+7
    do_op(3'b000, 32'd5, 32'd7);
    @(negedge clk); chk("lat_early", out_valid, 0);
    @(negedge clk); chk("lat_valid", out_valid, 1); chk("lat_result", result, 32'd12);
    chk("lat_zero", zero, 0); chk("lat_illegal", illegal, 0);
    @(posedge clk); #1;

    // 2, 3: arithmetic corners
    do_op(3'b001, 32'd9, 32'd9);
    expect_out("sub_eq", 32'd0, 1, 0, 1, 3'b100);
    do_op(3'b001, 32'd0, 32'd1);
    expect_out("sub_neg", 32'hFFFF_FFFF, 0, 0, 1, 3'b001);
    do_op(3'b101, 32'hFFFF_FFFF, 32'd1);
    expect_out("slt_neg", 32'd1, 0, 0, 1, 3'b000);
    do_op(3'b101, 32'd1, 32'hFFFF_FFFF);
    expect_out("slt_pos", 32'd0, 1, 0, 1, 3'b000);
    do_op(3'b000, 32'hFFFF_FFFF, 32'd1);
    expect_out("add_wrap", 32'd0, 1, 0, 1, 3'b100);
    do_op(3'b000, 32'h7FFF_FFFF, 32'd1);
    expect_out("add_ovf", 32'h8000_0000, 0, 0, 1, 3'b011);

    // 4: stall with three back-to-back ops
    out_ready = 0;
    in_valid = 1; alu_control = 3'b010; src_a = 32'hF0F0; src_b = 32'hFF00;
    @(posedge clk); #1;
    alu_control = 3'b011; src_a = 32'hF0F0; src_b = 32'h000F;
    @(posedge clk); #1;
    alu_control = 3'b000; src_a = 32'd1; src_b = 32'd1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", result, 32'hF000);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk); chk("drain0", result, 32'hF000); chk("drain0_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk); chk("drain1", result, 32'hF0FF); chk("drain1_valid", out_valid, 1);
    @(negedge clk); chk("drain2", result, 32'd2); chk("drain2_valid", out_valid, 1);
    @(posedge clk); #1;

    // 5: illegal code flows through, next legal op clears it
    do_op(3'b110, 32'd3, 32'd4);
    expect_out("illegal", 32'd0, 1, 1, 1, 3'b000);
    do_op(3'b000, 32'd3, 32'd4);
    expect_out("legal_after", 32'd7, 0, 0, 1, 3'b000);

    // 6: asynchronous reset with two ops in flight
    out_ready = 0;
    do_op(3'b000, 32'd1, 32'd1);
    do_op(3'b000, 32'd2, 32'd2);
    #3 rst = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_result", result, 0);
    chk("async_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1; out_ready = 1;
    repeat (3) begin
      @(negedge clk); chk("no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    do_op(3'b000, 32'd2, 32'd3);
    @(negedge clk); chk("post_rst_early", out_valid, 0);
    @(negedge clk); chk("post_rst_valid", out_valid, 1); chk("post_rst_result", result, 32'd5);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_control = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 5))
          0: v = 32'h0;
          1: v = 32'hFFFF_FFFF;
          2: v = 32'h7FFF_FFFF;
          3: v = 32'h8000_0000;
          default: v = $urandom;
        endcase
        if (k == 0) src_a = v; else src_b = v;
      end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
